// File: rtl/hamming_uart_rx_pkg.sv
// Shared definitions for the Hamming-coded UART link: default line timing,
// receiver state encoding, byte bit positions and the 7-segment cathode table.
package hamming_uart_rx_pkg;

    localparam int CLK_SPEED_DEFAULT    = 100_000_000;
    localparam int BAUD_RATE_DEFAULT    = 115_200;
    localparam int REFRESH_BITS_DEFAULT = 20;

    // Receiver FSM states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DECODE
    } rx_state_t;

    // Bit positions inside the coded byte {p5,d3,d2,d1,p4,d0,p2,p1}.
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D0 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_P5 = 7;

    // Result of one SECDED decode.
    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syndrome;
        logic       err_single;
        logic       err_double;
    } decode_t;

    // Active-low cathode patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Decimal digit to active-low cathodes; anything above 9 is blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/hamming_uart_rx_seven_seg_mux.sv
// Time-multiplexed 4-digit 7-segment driver. The two left digits stay blank;
// the two right digits show a 0-15 value as tens and ones.
module seven_seg_mux
    import hamming_uart_rx_pkg::*;
#(
    parameter int REFRESH_BITS = REFRESH_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic [3:0] an
);

    logic [REFRESH_BITS-1:0] refresh_ctr;
    logic [1:0]              sel;
    logic [3:0]              tens;
    logic [3:0]              ones;
    logic [6:0]              seg_next;
    logic [3:0]              an_next;

    // Free-running refresh counter; its top two bits pick the digit.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) refresh_ctr <= '0;
        else     refresh_ctr <= refresh_ctr + 1'b1;
    end

    assign sel = refresh_ctr[REFRESH_BITS-1 -: 2];

    // Split the value into decimal digits and choose anode/cathodes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        tens     = 4'd0;
        ones     = value;
        an_next  = 4'b0111;
        seg_next = SEG_BLANK;
        if (value >= 4'd10) begin
            tens = 4'd1;
            ones = value - 4'd10;
        end
        case (sel)
            2'd0: begin
                an_next  = 4'b0111;
                seg_next = SEG_BLANK;
            end
            2'd1: begin
                an_next  = 4'b1011;
                seg_next = SEG_BLANK;
            end
            2'd2: begin
                an_next  = 4'b1101;
                seg_next = seg_decode(tens);
            end
            default: begin
                an_next  = 4'b1110;
                seg_next = seg_decode(ones);
            end
        endcase
    end

    // Register anode and cathodes together so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b0111;
            seg <= SEG_ZERO;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: rtl/hamming_uart_rx.sv
// UART 8N1 receiver with Hamming(8,4) SECDED decode. One coded nibble per
// frame; single-bit errors are corrected, double-bit errors are flagged, and
// the corrected value is shown in decimal on the 7-segment display.
module hamming_uart_rx
    import hamming_uart_rx_pkg::*;
#(
    parameter int CLK_SPEED    = CLK_SPEED_DEFAULT,
    parameter int BAUD_RATE    = BAUD_RATE_DEFAULT,
    parameter int REFRESH_BITS = REFRESH_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] num_out,
    output logic [7:0] raw_byte,
    output logic [2:0] syndrome,
    output logic       valid,
    output logic       err_single,
    output logic       err_double,
    output logic       frame_err,
    output logic [6:0] seg2,
    output logic [3:0] an2
);

    localparam int CLK_CYCLES = CLK_SPEED / BAUD_RATE;
    localparam int CTR_W      = $clog2(CLK_CYCLES);

    localparam logic [CTR_W-1:0] FULL_LAST = CTR_W'(CLK_CYCLES - 1);
    localparam logic [CTR_W-1:0] HALF_LAST = CTR_W'(CLK_CYCLES / 2 - 1);

    rx_state_t        state;
    rx_state_t        next_state;
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic             rx_prev;
    logic [CTR_W-1:0] clk_ctr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             ctr_clear;
    logic             ctr_inc;
    logic             idx_clear;
    logic             shift_en;
    logic             frame_err_next;
    logic             decode_en;

    logic             s1;
    logic             s2;
    logic             s4;
    logic             parity;
    logic [2:0]       flip_pos;
    logic [7:0]       corrected;
    decode_t          dec;

    // Two-flop synchronizer for the asynchronous line, plus one more flop of
    // history for start-edge detection. All idle high so reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = rx_sync[1];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and datapath control for one frame.
    always_comb begin
        next_state     = state;
        ctr_clear      = 1'b0;
        ctr_inc        = 1'b0;
        idx_clear      = 1'b0;
        shift_en       = 1'b0;
        frame_err_next = 1'b0;
        decode_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                ctr_clear = 1'b1;
                if (rx_prev && !rx_s) next_state = ST_START;
            end
            ST_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                if (clk_ctr == HALF_LAST) begin
                    ctr_clear = 1'b1;
                    if (rx_s) begin
                        next_state = ST_IDLE;
                    end else begin
                        idx_clear  = 1'b1;
                        next_state = ST_DATA;
                    end
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_ctr == FULL_LAST) begin
                    ctr_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7) next_state = ST_STOP;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            ST_STOP: begin
                if (clk_ctr == FULL_LAST) begin
                    ctr_clear = 1'b1;
                    if (rx_s) begin
                        next_state = ST_DECODE;
                    end else begin
                        frame_err_next = 1'b1;
                        next_state     = ST_IDLE;
                    end
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                decode_en  = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ctr <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (ctr_clear)    clk_ctr <= '0;
            else if (ctr_inc) clk_ctr <= clk_ctr + CTR_W'(1);

            if (idx_clear)     bit_idx <= 3'd0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;

            if (shift_en) shreg[bit_idx] <= rx_s;
        end
    end

    // SECDED decode of the captured byte.
    always_comb begin
        s1 = shreg[POS_P1] ^ shreg[POS_D0] ^ shreg[POS_D1] ^ shreg[POS_D3];
        s2 = shreg[POS_P2] ^ shreg[POS_D0] ^ shreg[POS_D2] ^ shreg[POS_D3];
        s4 = shreg[POS_P4] ^ shreg[POS_D1] ^ shreg[POS_D2] ^ shreg[POS_D3];
        parity   = ^shreg;
        flip_pos = {s4, s2, s1} - 3'd1;
        corrected = shreg;
        // Odd overall parity with a non-zero syndrome points at the bad bit;
        // a zero syndrome with odd parity means only p5 was hit.
        if (parity && ({s4, s2, s1} != 3'd0)) begin
            corrected = shreg ^ (8'b0000_0001 << flip_pos);
        end
        dec.syndrome   = {s4, s2, s1};
        dec.err_single = parity;
        dec.err_double = !parity && ({s4, s2, s1} != 3'd0);
        dec.data       = {corrected[POS_D3], corrected[POS_D2],
                          corrected[POS_D1], corrected[POS_D0]};
    end

    // Output registers: results and flags change only on a good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_out    <= 4'd0;
            raw_byte   <= 8'h00;
            syndrome   <= 3'd0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid     <= decode_en;
            frame_err <= frame_err_next;
            if (decode_en) begin
                num_out    <= dec.data;
                raw_byte   <= shreg;
                syndrome   <= dec.syndrome;
                err_single <= dec.err_single;
                err_double <= dec.err_double;
            end
        end
    end

    seven_seg_mux #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_display (
        .clk  (clk),
        .rst  (rst),
        .value(num_out),
        .seg  (seg2),
        .an   (an2)
    );

endmodule

// File: tb/tb_hamming_uart_rx.sv
// Scoreboarded bench for hamming_uart_rx: directed frames, then random
// codewords with 0/1/2 bit errors, random bytes and random bad stop bits.
module tb_hamming_uart_rx;

    // Fast line: 32 clocks per bit, short display refresh.
    localparam int CLK_SPEED    = 3200;
    localparam int BAUD_RATE    = 100;
    localparam int BIT          = CLK_SPEED / BAUD_RATE;
    localparam int REFRESH_BITS = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [3:0] num_out;
    logic [7:0] raw_byte;
    logic [2:0] syndrome;
    logic       valid;
    logic       err_single;
    logic       err_double;
    logic       frame_err;
    logic [6:0] seg2;
    logic [3:0] an2;

    hamming_uart_rx #(
        .CLK_SPEED   (CLK_SPEED),
        .BAUD_RATE   (BAUD_RATE),
        .REFRESH_BITS(REFRESH_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .num_out   (num_out),
        .raw_byte  (raw_byte),
        .syndrome  (syndrome),
        .valid     (valid),
        .err_single(err_single),
        .err_double(err_double),
        .frame_err (frame_err),
        .seg2      (seg2),
        .an2       (an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic [7:0] raw;
        logic [2:0] syn;
        logic       es;
        logic       ed;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_ferr  = 0;
    int   seen_ferr = 0;

    logic [6:0] seg_ref [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Codeword for a nibble: data at positions 2,4,5,6; p1/p2/p4 cover the
    // positions whose 1-based index has that bit set; p5 makes parity even.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] b;
        b = 8'h00;
        b[2] = d[0];
        b[4] = d[1];
        b[5] = d[2];
        b[6] = d[3];
        b[0] = b[2] ^ b[4] ^ b[6];
        b[1] = b[2] ^ b[5] ^ b[6];
        b[3] = b[4] ^ b[5] ^ b[6];
        b[7] = ^b[6:0];
        return b;
    endfunction

    // Reference decode: syndrome is the XOR of the 1-based positions of set
    // bits in b[6:0]; the data is the nearest codeword's value.
    function automatic exp_t model(input logic [7:0] b);
        exp_t e;
        int   best_d;
        int   d;
        logic [3:0] best_v;
        e.syn  = 3'd0;
        for (int i = 0; i < 7; i++) if (b[i]) e.syn ^= 3'(i + 1);
        best_d = 99;
        best_v = 4'd0;
        for (int v = 0; v < 16; v++) begin
            d = $countones(b ^ encode(4'(v)));
            if (d < best_d) begin
                best_d = d;
                best_v = 4'(v);
            end
        end
        e.raw = b;
        e.es  = (best_d == 1);
        e.ed  = (best_d >= 2);
        e.num = (best_d <= 1) ? best_v : {b[6], b[5], b[4], b[2]};
        return e;
    endfunction

    // Drive start, the first nbits data bits and (for a full frame) a stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (nbits == 8) begin
            rx = stop_bit;
            repeat (BIT) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        if (stop_ok) begin
            e = model(b);
            exp_q.push_back(e);
            last_exp = e;
            send_frame(b, 1'b1, 8);
        end else begin
            exp_ferr++;
            send_frame(b, 1'b0, 8);
            repeat (BIT) @(negedge clk);
            check("hold_num_out", 32'(num_out), 32'(last_exp.num));
            check("hold_raw_byte", 32'(raw_byte), 32'(last_exp.raw));
            check("hold_syndrome", 32'(syndrome), 32'(last_exp.syn));
            check("hold_err_single", 32'(err_single), 32'(last_exp.es));
            check("hold_err_double", 32'(err_double), 32'(last_exp.ed));
        end
    endtask

    task automatic check_display();
        logic [3:0] seen;
        int         n;
        seen = 4'b0000;
        n    = int'(last_exp.num);
        for (int c = 0; c < 4 * (1 << REFRESH_BITS); c++) begin
            @(negedge clk);
            case (an2)
                4'b0111: begin seen[3] = 1'b1; check("seg_blank3", 32'(seg2), 32'h7F); end
                4'b1011: begin seen[2] = 1'b1; check("seg_blank2", 32'(seg2), 32'h7F); end
                4'b1101: begin seen[1] = 1'b1; check("seg_tens", 32'(seg2), 32'(seg_ref[n / 10])); end
                4'b1110: begin seen[0] = 1'b1; check("seg_ones", 32'(seg2), 32'(seg_ref[n % 10])); end
                default: check("an2_pattern", 32'(an2), 32'h7);
            endcase
        end
        check("digits_scanned", 32'(seen), 32'hF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_num_out"}, 32'(num_out), 32'h0);
        check({tag, "_raw_byte"}, 32'(raw_byte), 32'h0);
        check({tag, "_syndrome"}, 32'(syndrome), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_err_single"}, 32'(err_single), 32'h0);
        check({tag, "_err_double"}, 32'(err_double), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_an2"}, 32'(an2), 32'h7);
        check({tag, "_seg2"}, 32'(seg2), 32'h40);
    endtask

    // Monitor: every valid pulse pops one expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) seen_ferr++;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: num_out=%0h raw_byte=%0h with no frame pending at %0t",
                             num_out, raw_byte, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("num_out", 32'(num_out), 32'(mon_e.num));
                    check("raw_byte", 32'(raw_byte), 32'(mon_e.raw));
                    check("syndrome", 32'(syndrome), 32'(mon_e.syn));
                    check("err_single", 32'(err_single), 32'(mon_e.es));
                    check("err_double", 32'(err_double), 32'(mon_e.ed));
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [3:0] v;
        int         p;
        int         q;
        int         kind;

        last_exp = '{num: 4'd0, raw: 8'h00, syn: 3'd0, es: 1'b0, ed: 1'b0};
        rx  = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Directed frames around the codeword for 4'hB.
        send_byte(8'h55, 1'b1);
        check_display();
        send_byte(8'h51, 1'b1);
        send_byte(8'hD5, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);

        // Glitch shorter than half a bit: must be rejected as a false start.
        rx = 1'b0;
        repeat (BIT / 2 - 6) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Reset in the middle of the data bits, then a clean frame.
        send_frame(8'hA6, 1'b1, 4);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        last_exp = '{num: 4'd0, raw: 8'h00, syn: 3'd0, es: 1'b0, ed: 1'b0};
        @(negedge clk);
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
        send_byte(8'h55, 1'b1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            v    = 4'($urandom_range(0, 15));
            p    = $urandom_range(0, 7);
            q    = (p + $urandom_range(1, 7)) % 8;
            case (kind)
                0:       b = 8'($urandom);
                1:       b = encode(v);
                2:       b = encode(v) ^ (8'h01 << p);
                default: b = encode(v) ^ (8'h01 << p) ^ (8'h01 << q);
            endcase
            send_byte(b, ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, BIT)) @(negedge clk);
        end

        // Drain the scoreboard with a bounded wait.
        for (int c = 0; c < 4 * BIT && exp_q.size() != 0; c++) @(negedge clk);
        check("frames_outstanding", 32'(exp_q.size()), 32'h0);
        check("frame_err_pulses", 32'(seen_ferr), 32'(exp_ferr));
        check_display();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
